train_sample_sequencer: RTL and testbench

//   Host-side driver for one output-layer MatMul stage; runs one training sample end to end.

---
 rtl/train_sample_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_train_sample_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/train_sample_sequencer.sv
// Host driver for one output-layer MatMul stage: forward pass, capture, backprop, capture, done.
// Latency: 1 issue cycle + MatMul forward wait + 1 ack + backprop wait + 1 ack + 1 done cycle.
// Backpressure: waits on mm_valid per phase; watchdog abort built only with TRAIN_SEQ_TIMEOUT_EN.
module train_sample_sequencer #(
    parameter int PK_WIDTH    = 7,
    parameter int PK_LEN      = 9,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [PK_WIDTH*PK_LEN-1:0]   sample_in,
    input  logic [PK_WIDTH*PK_LEN-1:0]   target_in,
    output logic                         busy,
    output logic                         done,
    output logic                         timeout,
    output logic [PK_WIDTH*PK_LEN-1:0]   result_out,
    output logic [PK_WIDTH*PK_LEN-1:0]   delta_out,
    output logic [9:0]                   err_sum,
    output logic [15:0]                  sample_cnt,
    output logic                         mm_mult,
    output logic                         mm_backprop,
    output logic                         mm_ack,
    output logic                         mm_output_layer,
    output logic [PK_WIDTH*PK_LEN-1:0]   mm_data_out,
    input  logic                         mm_valid,
    input  logic [PK_WIDTH*PK_LEN-1:0]   mm_data_in
);

    localparam int VW = PK_WIDTH * PK_LEN;
    localparam int DW = 11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE_FWD,
        S_WAIT_FWD,
        S_ACK_FWD,
        S_WAIT_BACK,
        S_ACK_BACK,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [VW-1:0]   r_sample;
    logic [VW-1:0]   r_target;
    logic [VW-1:0]   r_result;
    logic [VW-1:0]   r_delta;
    logic [9:0]      r_err_sum;
    logic [15:0]     r_sample_cnt;

`ifdef TRAIN_SEQ_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0]   r_tmo_cnt;
    logic            r_timeout;
    logic            w_tmo_hit;
`endif

    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        busy        = (r_state != S_IDLE);
        done        = 1'b0;
        mm_mult     = 1'b0;
        mm_backprop = 1'b0;
        mm_ack      = 1'b0;
        mm_data_out = '0;
`ifdef TRAIN_SEQ_TIMEOUT_EN
        w_tmo_hit   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_ISSUE_FWD;
            end
            S_ISSUE_FWD: begin
                mm_mult     = 1'b1;
                mm_data_out = r_sample;
                w_next      = S_WAIT_FWD;
            end
            S_WAIT_FWD: begin
                mm_data_out = r_sample;
                if (mm_valid) w_next = S_ACK_FWD;
`ifdef TRAIN_SEQ_TIMEOUT_EN
                else if (r_tmo_cnt == TMO_LAST) begin
                    w_tmo_hit = 1'b1;
                    w_next    = S_IDLE;
                end
`endif
            end
            S_ACK_FWD: begin
                mm_ack = 1'b1;
                w_next = S_WAIT_BACK;
            end
            S_WAIT_BACK: begin
                // backprop stays high until valid so the stage sees it after its F' cycle
                mm_data_out = r_target;
                mm_backprop = 1'b1;
                if (mm_valid) w_next = S_ACK_BACK;
`ifdef TRAIN_SEQ_TIMEOUT_EN
                else if (r_tmo_cnt == TMO_LAST) begin
                    w_tmo_hit = 1'b1;
                    w_next    = S_IDLE;
                end
`endif
            end
            S_ACK_BACK: begin
                mm_ack = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    logic signed [DW-1:0] w_lane_a;
    logic signed [DW-1:0] w_lane_y;
    logic signed [DW-1:0] w_diff;
    logic        [DW-1:0] w_abs;
    logic        [DW:0]   w_abs_sum;
    logic        [9:0]    w_err_sat;

    // per-lane |a - y| at 11-bit signed width, summed, then clamped to the 10-bit output
    always_comb begin
        w_lane_a  = '0;
        w_lane_y  = '0;
        w_diff    = '0;
        w_abs     = '0;
        w_abs_sum = '0;
        for (int i = 0; i < PK_LEN; i++) begin
            w_lane_a  = {{(DW-PK_WIDTH){r_result[i*PK_WIDTH+PK_WIDTH-1]}},
                         r_result[i*PK_WIDTH +: PK_WIDTH]};
            w_lane_y  = {{(DW-PK_WIDTH){r_target[i*PK_WIDTH+PK_WIDTH-1]}},
                         r_target[i*PK_WIDTH +: PK_WIDTH]};
            w_diff    = w_lane_a - w_lane_y;
            w_abs     = w_diff[DW-1] ? -w_diff : w_diff;
            w_abs_sum = w_abs_sum + {1'b0, w_abs};
        end
        w_err_sat = (w_abs_sum > (DW+1)'(1023)) ? 10'd1023 : w_abs_sum[9:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sample     <= '0;
            r_target     <= '0;
            r_result     <= '0;
            r_delta      <= '0;
            r_err_sum    <= '0;
            r_sample_cnt <= '0;
        end else begin
            if (r_state == S_IDLE && start) begin
                r_sample <= sample_in;
                r_target <= target_in;
            end
            if (r_state == S_WAIT_FWD && mm_valid)  r_result <= mm_data_in;
            if (r_state == S_ACK_FWD)               r_err_sum <= w_err_sat;
            if (r_state == S_WAIT_BACK && mm_valid) r_delta <= mm_data_in;
            if (r_state == S_DONE)                  r_sample_cnt <= r_sample_cnt + 16'd1;
        end
    end

`ifdef TRAIN_SEQ_TIMEOUT_EN
    // wait states are never adjacent, so clearing outside them clears on each entry
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_tmo_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (r_state == S_WAIT_FWD || r_state == S_WAIT_BACK) r_tmo_cnt <= r_tmo_cnt + 1'b1;
            else                                                 r_tmo_cnt <= '0;
            if (r_state == S_IDLE && start) r_timeout <= 1'b0;
            else if (w_tmo_hit)             r_timeout <= 1'b1;
        end
    end
    assign timeout = r_timeout;
`else
    assign timeout = 1'b0;
`endif

    assign result_out      = r_result;
    assign delta_out       = r_delta;
    assign err_sum         = r_err_sum;
    assign sample_cnt      = r_sample_cnt;
    assign mm_output_layer = 1'b1;

endmodule

// File: tb/tb_train_sample_sequencer.sv
// Bench for train_sample_sequencer with a behavioural MatMul responder and a scoreboard queue.
`timescale 1ns/1ps
module tb_train_sample_sequencer;

    localparam int VW = 63;
`ifdef TRAIN_SEQ_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 64;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [VW-1:0] sample_in = '0;
    logic [VW-1:0] target_in = '0;
    logic          busy, done, timeout;
    logic [VW-1:0] result_out, delta_out, mm_data_out;
    logic [9:0]    err_sum;
    logic [15:0]   sample_cnt;
    logic          mm_mult, mm_backprop, mm_ack, mm_output_layer;
    logic          mm_valid;
    logic [VW-1:0] mm_data_in = '0;
    logic          resp_valid = 1'b0;
    logic          force_valid = 1'b0;

    assign mm_valid = resp_valid | force_valid;

    train_sample_sequencer #(.PK_WIDTH(7), .PK_LEN(9), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset(reset), .start(start),
        .sample_in(sample_in), .target_in(target_in),
        .busy(busy), .done(done), .timeout(timeout),
        .result_out(result_out), .delta_out(delta_out),
        .err_sum(err_sum), .sample_cnt(sample_cnt),
        .mm_mult(mm_mult), .mm_backprop(mm_backprop), .mm_ack(mm_ack),
        .mm_output_layer(mm_output_layer), .mm_data_out(mm_data_out),
        .mm_valid(mm_valid), .mm_data_in(mm_data_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VW-1:0] res;
        logic [9:0]    err;
        logic [VW-1:0] dlt;
        logic [VW-1:0] smp;
        logic [VW-1:0] tgt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_mult = 0, n_done = 0, n_bp = 0;
    int   exp_cnt = 0;

    logic [VW-1:0] rsp_fwd = '0, rsp_dlt = '0, seen_fwd = '0, seen_back = '0;
    int            rsp_fd = 0, rsp_bd = 0;
    bit            rsp_mute = 1'b0;

    function automatic logic [VW-1:0] rep(input logic [6:0] l);
        return {9{l}};
    endfunction

    function automatic logic [9:0] model_err(input logic [VW-1:0] a, input logic [VW-1:0] y);
        int s, ai, yi;
        logic [6:0] la, ly;
        s = 0;
        for (int i = 0; i < 9; i++) begin
            la = a[i*7 +: 7];
            ly = y[i*7 +: 7];
            ai = int'($signed(la));
            yi = int'($signed(ly));
            s += (ai > yi) ? ai - yi : yi - ai;
        end
        if (s > 1023) s = 1023;
        return s[9:0];
    endfunction

    // strobe counters, sampled after outputs settle
    always @(posedge clk) begin
        #2;
        if (mm_mult)     n_mult++;
        if (done)        n_done++;
        if (mm_backprop) n_bp++;
    end

    // behavioural MatMul: valid after a programmable delay, held until ack
    initial begin : responder
        int rs, cnt;
        rs = 0;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!reset || rsp_mute) begin
                rs = 0;
                resp_valid = 1'b0;
            end else begin
                if (rs == 0 && mm_mult) begin
                    seen_fwd = mm_data_out;
                    cnt = rsp_fd;
                    rs = 1;
                end
                if (rs == 1) begin
                    if (cnt == 0) begin
                        resp_valid = 1'b1;
                        mm_data_in = rsp_fwd;
                        rs = 2;
                    end else cnt--;
                end else if (rs == 2 && mm_ack) begin
                    resp_valid = 1'b0;
                    cnt = rsp_bd;
                    rs = 3;
                end else if (rs == 3 && mm_backprop) begin
                    if (cnt == 0) begin
                        seen_back = mm_data_out;
                        resp_valid = 1'b1;
                        mm_data_in = rsp_dlt;
                        rs = 4;
                    end else cnt--;
                end else if (rs == 4 && mm_ack) begin
                    resp_valid = 1'b0;
                    rs = 0;
                end
            end
        end
    end

    task automatic kick(input logic [VW-1:0] s, input logic [VW-1:0] y,
                        input logic [VW-1:0] f, input logic [VW-1:0] d,
                        input int fd, input int bd);
        exp_t e;
        rsp_fwd = f; rsp_dlt = d; rsp_fd = fd; rsp_bd = bd;
        sample_in = s; target_in = y;
        e.res = f; e.err = model_err(f, y); e.dlt = d; e.smp = s; e.tgt = y;
        sb.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sample_in = '0;
        target_in = '0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (mm_mult !== 1'b0) begin n_fail++; $display("FAIL reset_mult: got %b want 0", mm_mult); end
        n_checks++; if (mm_backprop !== 1'b0) begin n_fail++; $display("FAIL reset_backprop: got %b want 0", mm_backprop); end
        n_checks++; if (mm_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", mm_ack); end
        n_checks++; if (mm_output_layer !== 1'b1) begin n_fail++; $display("FAIL reset_outlayer: got %b want 1", mm_output_layer); end
        n_checks++; if (sample_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", sample_cnt); end
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        n_checks++; if (err_sum !== 10'd0) begin n_fail++; $display("FAIL reset_err: got %0d want 0", err_sum); end
        n_checks++; if (result_out !== '0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result_out); end
        n_checks++; if (mm_data_out !== '0) begin n_fail++; $display("FAIL reset_mmdata: got %h want 0", mm_data_out); end
        start = 1'b0; reset = 1'b1;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        int m0, d0, b0;
        bit ok;
        exp_t e;
        m0 = n_mult; d0 = n_done; b0 = n_bp;
        kick(rep(7'd1), rep(7'd2), rep(7'd5), rep(7'h7F), 0, 0);
        wait_done(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL basic_done_wait: got no done want done within bound"); end
        e = sb.pop_front(); exp_cnt++;
        n_checks++; if (result_out !== e.res) begin n_fail++; $display("FAIL basic_result: got %h want %h", result_out, e.res); end
        n_checks++; if (err_sum !== 10'd27) begin n_fail++; $display("FAIL basic_err: got %0d want 27", err_sum); end
        n_checks++; if (delta_out !== e.dlt) begin n_fail++; $display("FAIL basic_delta: got %h want %h", delta_out, e.dlt); end
        n_checks++; if (n_mult - m0 != 1) begin n_fail++; $display("FAIL basic_mult_pulses: got %0d want 1", n_mult - m0); end
        n_checks++; if (n_done - d0 != 1) begin n_fail++; $display("FAIL basic_done_pulses: got %0d want 1", n_done - d0); end
        n_checks++; if (n_bp - b0 != 1) begin n_fail++; $display("FAIL basic_bp_cycles: got %0d want 1", n_bp - b0); end
        n_checks++; if (sample_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL basic_cnt: got %0d want %0d", sample_cnt, exp_cnt); end
        n_checks++; if (seen_fwd !== e.smp) begin n_fail++; $display("FAIL basic_fwd_data: got %h want %h", seen_fwd, e.smp); end
        n_checks++; if (seen_back !== e.tgt) begin n_fail++; $display("FAIL basic_back_data: got %h want %h", seen_back, e.tgt); end
        n_checks++; if (busy !== 1'b0 || mm_backprop !== 1'b0) begin n_fail++; $display("FAIL basic_idle: got busy=%b bp=%b want 0 0", busy, mm_backprop); end
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %b want 0", timeout); end
    endtask

    task automatic test_negative();
        int b0;
        bit ok;
        exp_t e;
        b0 = n_bp;
        kick(rep(7'd3), rep(7'd4), rep(7'h7D), rep(7'h15), 1, 3);
        wait_done(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL neg_done_wait: got no done want done within bound"); end
        e = sb.pop_front(); exp_cnt++;
        n_checks++; if (err_sum !== 10'd63) begin n_fail++; $display("FAIL neg_err: got %0d want 63", err_sum); end
        n_checks++; if (result_out !== e.res) begin n_fail++; $display("FAIL neg_result: got %h want %h", result_out, e.res); end
        n_checks++; if (delta_out !== e.dlt) begin n_fail++; $display("FAIL neg_delta: got %h want %h", delta_out, e.dlt); end
        n_checks++; if (n_bp - b0 != 4) begin n_fail++; $display("FAIL neg_bp_hold: got %0d cycles want 4", n_bp - b0); end
        n_checks++; if (mm_backprop !== 1'b0) begin n_fail++; $display("FAIL neg_bp_drop: got %b want 0", mm_backprop); end
        n_checks++; if (sample_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL neg_cnt: got %0d want %0d", sample_cnt, exp_cnt); end
    endtask

    task automatic test_ignore();
        int m0, d0;
        bit ok, stray;
        exp_t e;
        m0 = n_mult; d0 = n_done;
        kick(rep(7'd2), rep(7'd1), rep(7'h10), rep(7'h01), 6, 2);
        repeat (2) @(negedge clk);
        start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_done(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL ign_done_wait: got no done want done within bound"); end
        e = sb.pop_front(); exp_cnt++;
        repeat (5) @(negedge clk);
        n_checks++; if (n_done - d0 != 1) begin n_fail++; $display("FAIL ign_done_count: got %0d want 1", n_done - d0); end
        n_checks++; if (n_mult - m0 != 1) begin n_fail++; $display("FAIL ign_mult_count: got %0d want 1", n_mult - m0); end
        n_checks++; if (err_sum !== e.err) begin n_fail++; $display("FAIL ign_err: got %0d want %0d", err_sum, e.err); end
        force_valid = 1'b1;
        stray = 1'b0;
        repeat (4) begin @(negedge clk); if (busy) stray = 1'b1; end
        force_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (stray) begin n_fail++; $display("FAIL ign_valid_idle_busy: got busy=1 want 0"); end
        n_checks++; if (result_out !== e.res) begin n_fail++; $display("FAIL ign_valid_idle_result: got %h want %h", result_out, e.res); end
        n_checks++; if (sample_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL ign_cnt: got %0d want %0d", sample_cnt, exp_cnt); end
    endtask

    task automatic test_saturation();
        logic [VW-1:0] a, y;
        bit ok;
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            a = rep(7'h40);
            y = rep(7'h3F);
            if (k == 1) begin
                a[62:56] = 7'h00;
                y[62:56] = 7'h06;
            end
            kick(rep(7'd9), y, a, rep(7'h22), 0, 1);
            wait_done(ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL sat%0d_done_wait: got no done want done within bound", k); end
            e = sb.pop_front(); exp_cnt++;
            n_checks++; if (err_sum !== e.err) begin n_fail++; $display("FAIL sat%0d_err: got %0d want %0d", k, err_sum, e.err); end
        end
        n_checks++; if (err_sum !== 10'd1022) begin n_fail++; $display("FAIL sat_below_edge: got %0d want 1022", err_sum); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            kick(63'({$urandom(), $urandom()}), 63'({$urandom(), $urandom()}),
                 63'({$urandom(), $urandom()}), 63'({$urandom(), $urandom()}),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            wait_done(ok);
            n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b%0d_done_wait: got no done want done within bound", k); end
            e = sb.pop_front(); exp_cnt++;
            n_checks++; if (result_out !== e.res) begin n_fail++; $display("FAIL b2b%0d_result: got %h want %h", k, result_out, e.res); end
            n_checks++; if (err_sum !== e.err) begin n_fail++; $display("FAIL b2b%0d_err: got %0d want %0d", k, err_sum, e.err); end
            n_checks++; if (delta_out !== e.dlt) begin n_fail++; $display("FAIL b2b%0d_delta: got %h want %h", k, delta_out, e.dlt); end
            n_checks++; if (seen_back !== e.tgt) begin n_fail++; $display("FAIL b2b%0d_back_data: got %h want %h", k, seen_back, e.tgt); end
            n_checks++; if (sample_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL b2b%0d_cnt: got %0d want %0d", k, sample_cnt, exp_cnt); end
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        bit ok, seen;
        exp_t e;
        d0 = n_done;
        kick(rep(7'd1), rep(7'd1), rep(7'd1), rep(7'd1), 0, 20);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mm_backprop) begin seen = 1'b1; break; end
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL rmid_reach_wait_back: got no backprop want backprop within bound"); end
        reset = 1'b0;
        @(negedge clk);
        e = sb.pop_back(); exp_cnt = 0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
        n_checks++; if (mm_backprop !== 1'b0 || mm_ack !== 1'b0 || mm_mult !== 1'b0) begin n_fail++; $display("FAIL rmid_strobes: got bp=%b ack=%b mult=%b want 0 0 0", mm_backprop, mm_ack, mm_mult); end
        n_checks++; if (sample_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL rmid_cnt: got %0d want %0d", sample_cnt, exp_cnt); end
        reset = 1'b1;
        repeat (25) @(negedge clk);
        n_checks++; if (n_done != d0) begin n_fail++; $display("FAIL rmid_no_done: got %0d pulses want 0", n_done - d0); end
        n_checks++; if (busy !== 1'b0 || sample_cnt !== 16'(exp_cnt)) begin n_fail++; $display("FAIL rmid_after: got busy=%b cnt=%0d want 0 %0d", busy, sample_cnt, exp_cnt); end
        kick(rep(7'd6), rep(7'd3), rep(7'd3), rep(7'd2), 0, 0);
        wait_done(ok);
        e = sb.pop_front(); exp_cnt++;
        n_checks++; if (!ok || sample_cnt !== 16'(exp_cnt) || err_sum !== e.err) begin n_fail++; $display("FAIL rmid_recover: got ok=%b cnt=%0d err=%0d want 1 %0d %0d", ok, sample_cnt, err_sum, exp_cnt, e.err); end
    endtask

`ifdef TRAIN_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        int d0, cyc;
        bit ok;
        exp_t e;
        d0 = n_done;
        rsp_mute = 1'b1;
        kick(rep(7'd3), rep(7'd3), '0, '0, 0, 0);
        e = sb.pop_back();
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            cyc++;
            @(negedge clk);
        end
        n_checks++; if (cyc != 9) begin n_fail++; $display("FAIL tmo_busy_cycles: got %0d want 9", cyc); end
        n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_flag: got %b want 1", timeout); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_busy: got %b want 0", busy); end
        n_checks++; if (sample_cnt !== 16'(exp_cnt) || n_done != d0) begin n_fail++; $display("FAIL tmo_no_count: got cnt=%0d done=%0d want %0d 0", sample_cnt, n_done - d0, exp_cnt); end
        repeat (3) @(negedge clk);
        n_checks++; if (timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b want 1", timeout); end
        rsp_mute = 1'b0;
        kick(rep(7'd1), rep(7'd2), rep(7'd4), rep(7'd8), 0, 0);
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL tmo_clear: got %b want 0", timeout); end
        wait_done(ok);
        e = sb.pop_front(); exp_cnt++;
        n_checks++; if (!ok || sample_cnt !== 16'(exp_cnt) || err_sum !== e.err) begin n_fail++; $display("FAIL tmo_recover: got ok=%b cnt=%0d err=%0d want 1 %0d %0d", ok, sample_cnt, err_sum, exp_cnt, e.err); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_ignore();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
`ifdef TRAIN_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got no end of test want finish before time limit");
        $fatal(1);
    end

endmodule
